// File: rtl/seg_mmu_pkg.sv
// Shared constants for the segmented MMU: mode encodings and default parameter values.
package seg_mmu_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_SEG_W  = 32;
    localparam int DEF_NSEG   = 16;

    typedef enum logic {
        KERNEL_MODE = 1'b0,
        USER_MODE   = 1'b1
    } mode_e;

endpackage

// File: rtl/seg_table.sv
// Base/bound segment table: NSEG entries, one write port, one asynchronous read port.
// Bound storage exists only when SEG_MMU_BOUND_CHECK_EN is defined.
module seg_table
    import seg_mmu_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W,
    parameter int NSEG  = DEF_NSEG,
    parameter int SEL_W = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [SEL_W-1:0] wsel,
    input  logic [SEG_W-1:0] wbase,
    input  logic [SEG_W-1:0] wbound,
    input  logic [SEL_W-1:0] rsel,
    output logic [SEG_W-1:0] rbase,
    output logic [SEG_W-1:0] rbound
);

    logic [SEG_W-1:0] base_q [NSEG];
    logic             wr_ok;

    // Out-of-range indices are dropped rather than aliased onto a valid entry.
    assign wr_ok = we && (32'(wsel) < NSEG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NSEG; i++) base_q[i] <= '0;
        end else if (wr_ok) begin
            base_q[wsel] <= wbase;
        end
    end

    assign rbase = base_q[rsel];

`ifdef SEG_MMU_BOUND_CHECK_EN
    logic [SEG_W-1:0] bound_q [NSEG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NSEG; i++) bound_q[i] <= '0;
        end else if (wr_ok) begin
            bound_q[wsel] <= wbound;
        end
    end

    assign rbound = bound_q[rsel];
`else
    logic unused_wbound;
    assign unused_wbound = ^wbound;
    assign rbound        = '0;
`endif

endmodule

// File: rtl/seg_mmu.sv
// Segmented MMU: base-relative translation in user mode, pass-through in kernel mode.
// Bound/overflow fault checking is built only with SEG_MMU_BOUND_CHECK_EN defined.
module seg_mmu
    import seg_mmu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEG_W  = DEF_SEG_W,
    parameter int NSEG   = DEF_NSEG,
    parameter int SEL_W  = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [SEG_W-1:0]  base_in,
    input  logic [SEG_W-1:0]  bound_in,
    input  logic              sel_we,
    input  logic              userMode,
    input  logic              kernelMode,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clr,
    output logic              exec_mode
);

    localparam int CMP_W = (ADDR_W > SEG_W) ? ADDR_W : SEG_W;

    mode_e             mode_q, mode_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [SEG_W-1:0]  base_rd, bound_rd;
    logic [ADDR_W:0]   sum;
    logic              req_fault;
    logic              unused_ok;

    seg_table #(
        .SEG_W (SEG_W),
        .NSEG  (NSEG),
        .SEL_W (SEL_W)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wsel   (wsel),
        .wbase  (base_in),
        .wbound (bound_in),
        .rsel   (sel_q),
        .rbase  (base_rd),
        .rbound (bound_rd)
    );

    // Reads see the table, selector and mode as they were before this edge.
    assign sum       = {1'b0, addr_in} + {1'b0, ADDR_W'(base_rd)};
    assign unused_ok = ^{base_rd, bound_rd, sum};

`ifdef SEG_MMU_BOUND_CHECK_EN
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    assign req_fault = req_valid && (mode_q == USER_MODE) &&
                       (sum[ADDR_W] || (CMP_W'(addr_in) >= CMP_W'(bound_rd)));
`else
    assign req_fault = 1'b0;
`endif

    always_comb begin
        mode_d       = mode_q;
        sel_d        = sel_q;
        resp_valid_d = req_valid;
        addr_out_d   = addr_out_q;

        if (kernelMode) begin
            mode_d = KERNEL_MODE;
        end else if (userMode) begin
            mode_d = USER_MODE;
        end

        if (sel_we && (32'(wsel) < NSEG)) begin
            sel_d = wsel;
        end

        if (req_valid) begin
            if (mode_q == KERNEL_MODE) begin
                addr_out_d = addr_in;
            end else if (req_fault) begin
                addr_out_d = '0;
            end else begin
                addr_out_d = sum[ADDR_W-1:0];
            end
        end

`ifdef SEG_MMU_BOUND_CHECK_EN
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        // A new fault beats a same-cycle clear; the clear still lets the new address replace the old one.
        if (req_fault) begin
            mode_d  = KERNEL_MODE;
            fault_d = 1'b1;
            if (!fault_q || fault_clr) begin
                fault_addr_d = addr_in;
            end
        end else if (fault_clr) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= KERNEL_MODE;
            sel_q        <= '0;
            resp_valid_q <= 1'b0;
            addr_out_q   <= '0;
`ifdef SEG_MMU_BOUND_CHECK_EN
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
`endif
        end else begin
            mode_q       <= mode_d;
            sel_q        <= sel_d;
            resp_valid_q <= resp_valid_d;
            addr_out_q   <= addr_out_d;
`ifdef SEG_MMU_BOUND_CHECK_EN
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
`endif
        end
    end

    assign exec_mode  = mode_q;
    assign resp_valid = resp_valid_q;
    assign addr_out   = addr_out_q;
`ifdef SEG_MMU_BOUND_CHECK_EN
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_seg_mmu.sv
// Self-checking bench for seg_mmu: directed scenarios plus randomized traffic against a behavioural model.
module tb_seg_mmu;

    localparam int ADDR_W = 26;
    localparam int SEG_W  = 32;
    localparam int NSEG   = 16;
    localparam int SEL_W  = 4;
    localparam longint unsigned AMOD = 64'd1 << ADDR_W;
`ifdef SEG_MMU_BOUND_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              we;
    logic [SEL_W-1:0]  wsel;
    logic [SEG_W-1:0]  base_in;
    logic [SEG_W-1:0]  bound_in;
    logic              sel_we;
    logic              userMode;
    logic              kernelMode;
    logic              req_valid;
    logic [ADDR_W-1:0] addr_in;
    logic              resp_valid;
    logic [ADDR_W-1:0] addr_out;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;
    logic              fault_clr;
    logic              exec_mode;

    seg_mmu #(
        .ADDR_W (ADDR_W),
        .SEG_W  (SEG_W),
        .NSEG   (NSEG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wsel       (wsel),
        .base_in    (base_in),
        .bound_in   (bound_in),
        .sel_we     (sel_we),
        .userMode   (userMode),
        .kernelMode (kernelMode),
        .req_valid  (req_valid),
        .addr_in    (addr_in),
        .resp_valid (resp_valid),
        .addr_out   (addr_out),
        .fault      (fault),
        .fault_addr (fault_addr),
        .fault_clr  (fault_clr),
        .exec_mode  (exec_mode)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state
    longint unsigned m_base [NSEG];
    longint unsigned m_bound[NSEG];
    int unsigned     m_sel;
    bit              m_user;
    bit              m_fault;
    longint unsigned m_faddr;
    bit              m_resp;
    longint unsigned m_aout;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSEG; i++) begin
            m_base[i]  = 0;
            m_bound[i] = 0;
        end
        m_sel = 0; m_user = 0; m_fault = 0; m_faddr = 0; m_resp = 0; m_aout = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        longint unsigned a, s;
        bit flt;
        a   = longint'(addr_in);
        flt = 0;
        m_resp = req_valid;
        if (req_valid) begin
            if (!m_user) begin
                m_aout = a;
            end else begin
                s   = a + (m_base[m_sel] % AMOD);
                flt = CHK_EN && ((s >= AMOD) || (a >= m_bound[m_sel]));
                m_aout = flt ? 0 : (s % AMOD);
            end
        end
        if (kernelMode)    m_user = 0;
        else if (userMode) m_user = 1;
        if (flt) begin
            m_user = 0;
            if (!m_fault || fault_clr) m_faddr = a;
            m_fault = 1;
        end else if (fault_clr) begin
            m_fault = 0;
            m_faddr = 0;
        end
        if (we && int'(wsel) < NSEG) begin
            m_base[wsel]  = base_in;
            m_bound[wsel] = bound_in;
        end
        if (sel_we && int'(wsel) < NSEG) m_sel = wsel;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".resp_valid"}, resp_valid, m_resp);
        chk({pfx, ".addr_out"},   addr_out,   m_aout);
        chk({pfx, ".exec_mode"},  exec_mode,  m_user);
        chk({pfx, ".fault"},      fault,      m_fault);
        chk({pfx, ".fault_addr"}, fault_addr, m_faddr);
    endtask

    task automatic cycle(input string pfx);
        model_step();
        @(posedge clk);
        #1;
        check_all(pfx);
    endtask

    task automatic idle();
        we = 0; wsel = '0; base_in = '0; bound_in = '0; sel_we = 0;
        userMode = 0; kernelMode = 0; req_valid = 0; addr_in = '0; fault_clr = 0;
    endtask

    task automatic check_cleared(input string pfx);
        chk({pfx, ".resp_valid"}, resp_valid, 0);
        chk({pfx, ".addr_out"},   addr_out,   0);
        chk({pfx, ".exec_mode"},  exec_mode,  0);
        chk({pfx, ".fault"},      fault,      0);
        chk({pfx, ".fault_addr"}, fault_addr, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 0;

        // Kernel pass-through after reset
        req_valid = 1; addr_in = 26'h0001234;
        cycle("kpass");
        chk("kpass.const", addr_out, 26'h0001234);

        // User translation through segment 3
        idle(); we = 1; wsel = 3; base_in = 32'h100000; bound_in = 32'h8000;
        cycle("wr3");
        idle(); sel_we = 1; wsel = 3;
        cycle("sel3");
        idle(); userMode = 1;
        cycle("user");
        idle(); req_valid = 1; addr_in = 26'h0000040;
        cycle("xlate");
        chk("xlate.const", addr_out, 26'h0100040);
        chk("xlate.valid", resp_valid, 1);

        // Bound fault at exactly the bound
        idle(); req_valid = 1; addr_in = 26'h0008000;
        cycle("bound");
        if (CHK_EN) begin
            chk("bound.aout",  addr_out,   0);
            chk("bound.fault", fault,      1);
            chk("bound.faddr", fault_addr, 26'h0008000);
            chk("bound.mode",  exec_mode,  0);
        end else begin
            chk("bound.aout",  addr_out,   26'h0108000);
        end
        idle(); fault_clr = 1;
        cycle("fclr");
        chk("fclr.fault", fault, 0);

        // Simultaneous mode pulses: kernel wins
        idle(); userMode = 1; kernelMode = 1;
        cycle("both");
        chk("both.mode", exec_mode, 0);
        idle(); userMode = 1;
        cycle("user2");

        // Table write and request in the same cycle: old base used
        idle(); we = 1; wsel = 3; base_in = 32'h200000; bound_in = 32'h8000;
        req_valid = 1; addr_in = 26'h0000040;
        cycle("war");
        chk("war.const", addr_out, 26'h0100040);
        idle(); req_valid = 1; addr_in = 26'h0000040;
        cycle("war2");
        chk("war2.const", addr_out, 26'h0200040);

        // Hold when no request
        idle();
        cycle("hold");
        chk("hold.aout", addr_out, 26'h0200040);

        // Carry out of the translation sum
        idle(); we = 1; wsel = 3; base_in = 32'h3FFFFFF; bound_in = 32'hFFFFFFFF;
        cycle("wrovf");
        idle(); req_valid = 1; addr_in = 26'h0000002;
        cycle("ovf");
        if (CHK_EN) chk("ovf.fault", fault, 1);
        else        chk("ovf.aout",  addr_out, 26'h0000001);
        idle(); fault_clr = 1; userMode = 1;
        cycle("ovfclr");

        // Reset asserted while a request is in flight
        idle(); req_valid = 1; addr_in = 26'h0000123;
        #2;
        reset = 1;
        #1;
        check_cleared("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 0; req_valid = 0;
        cycle("postrst");
        chk("postrst.valid", resp_valid, 0);
        req_valid = 1; addr_in = 26'h0000777;
        cycle("postrst2");
        chk("postrst2.aout", addr_out, 26'h0000777);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            we         = ($urandom_range(0, 7) == 0);
            sel_we     = ($urandom_range(0, 7) == 0);
            wsel       = SEL_W'($urandom_range(0, NSEG - 1));
            base_in    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom % 32'h0400000);
            bound_in   = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : ($urandom % 32'h0800000);
            userMode   = ($urandom_range(0, 5) == 0);
            kernelMode = ($urandom_range(0, 11) == 0);
            fault_clr  = ($urandom_range(0, 9) == 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            addr_in    = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom % 32'h0400000);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
